// File: rtl/sensor_scheduler_pkg.sv
// Shared types and helpers for the sensor scheduler: FSM state encoding,
// default sample width and a one-hot to index converter.
package sensor_sched_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int MAX_CH         = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Index of the (single) set bit of a one-hot vector; zero when none is set.
  function automatic logic [3:0] grant_index(input logic [MAX_CH-1:0] onehot);
    grant_index = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (onehot[i]) grant_index = 4'(i);
    end
  endfunction

endpackage

// File: rtl/sensor_scheduler_if.sv
// Request, shared-datapath and response signals of the sensor scheduler.
// slave is the scheduler's view, master is the surrounding environment's view.
interface sensor_scheduler_if
  import sensor_sched_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = DEFAULT_DATA_W
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]        req;
  logic [N_CH*DATA_W-1:0] req_data;
  logic [N_CH-1:0]        req_ack;
  logic [DATA_W-1:0]      si_sensor_data;
  logic                   si_data_valid;
  logic [DATA_W-1:0]      si_processed_data;
  logic                   si_decision;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [CH_W-1:0]        rsp_ch;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_decision;
  logic                   busy;

  modport slave (
    input  req, req_data, si_processed_data, si_decision, rsp_ready,
    output req_ack, si_sensor_data, si_data_valid,
           rsp_valid, rsp_ch, rsp_data, rsp_decision, busy
  );

  modport master (
    output req, req_data, si_processed_data, si_decision, rsp_ready,
    input  req_ack, si_sensor_data, si_data_valid,
           rsp_valid, rsp_ch, rsp_data, rsp_decision, busy
  );

endinterface

// File: rtl/sensor_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// the pointer, wrapping at N_CH-1 back to channel 0.
module rr_arbiter
  import sensor_sched_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] pointer,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            any_req
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(pointer) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign grant_idx = CH_W'(grant_index(MAX_CH'(grant)));
  assign any_req   = |req;

endmodule

// File: rtl/sensor_scheduler.sv
// Shares one sensor datapath between N_CH channels: arbitrate, issue a single
// data_valid, wait RESULT_LAT cycles, capture the result and hand it back.
module sensor_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int RESULT_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sensor_scheduler_if.slave  bus
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(RESULT_LAT + 1);

  state_t            state, next_state;
  logic [CH_W-1:0]   ptr, grant_q, rsp_ch_q, arb_idx;
  logic [N_CH-1:0]   grant_oh_q, arb_grant;
  logic              arb_any;
  logic [DATA_W-1:0] sample_q, rsp_data_q;
  logic              rsp_dec_q;
  logic [CNT_W-1:0]  wait_cnt;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req       (bus.req),
    .pointer   (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (arb_any) next_state = ISSUE;
      ISSUE: next_state = WAIT;
      WAIT:  if (wait_cnt == CNT_W'(1)) next_state = RESP;
      RESP:  if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant, sample, wait counter, captured result and the fairness pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      grant_q    <= '0;
      grant_oh_q <= '0;
      sample_q   <= '0;
      wait_cnt   <= '0;
      rsp_ch_q   <= '0;
      rsp_data_q <= '0;
      rsp_dec_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arb_any) begin
          grant_q    <= arb_idx;
          grant_oh_q <= arb_grant;
          sample_q   <= bus.req_data[arb_idx*DATA_W +: DATA_W];
        end
        ISSUE: wait_cnt <= CNT_W'(RESULT_LAT);
        WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (wait_cnt == CNT_W'(1)) begin
            rsp_ch_q   <= grant_q;
            rsp_data_q <= bus.si_processed_data;
            rsp_dec_q  <= bus.si_decision;
          end
        end
        RESP: if (bus.rsp_ready) begin
          ptr <= (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ack        = (state == ISSUE) ? grant_oh_q : '0;
    bus.si_data_valid  = (state == ISSUE);
    bus.si_sensor_data = sample_q;
    bus.rsp_valid      = (state == RESP);
    bus.rsp_ch         = rsp_ch_q;
    bus.rsp_data       = rsp_data_q;
    bus.rsp_decision   = rsp_dec_q;
    bus.busy           = (state != IDLE);
  end

endmodule

// File: doc/sensor_scheduler.md
Name: sensor_scheduler

Overview:
Time-multiplexes one shared sensor_interface datapath between N_CH sensor channels. A round-robin arbiter picks one requesting channel and latches its sample. The block drives a single-cycle data_valid into the datapath, waits a fixed result latency, then captures processed_data/decision. The result returns to the requester on a valid/ready response port tagged with the channel index. Sits between the per-sensor front ends and the shared sensor_interface instance.

Parameters:
N_CH, 4, number of requesting sensor channels (2..16)
DATA_W, 16, sample and result width
RESULT_LAT, 1, cycles from the datapath's data_valid edge to a valid result (>=1)
CH_W, $clog2(N_CH), channel index width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req  in  N_CH  per-channel request, held until acked
req_data  in  N_CH*DATA_W  per-channel sample, channel i at [i*DATA_W +: DATA_W], stable while req[i]
req_ack  out  N_CH  one-hot, 1-cycle pulse: sample taken
si_sensor_data  out  DATA_W  to datapath sensor_data
si_data_valid  out  1  to datapath data_valid
si_processed_data  in  DATA_W  from datapath processed_data
si_decision  in  1  from datapath decision
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_ch  out  CH_W  channel the result belongs to
rsp_data  out  DATA_W  captured processed_data
rsp_decision  out  1  captured decision
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, rr pointer=0, grant=0, wait count=0. All outputs 0: req_ack, si_sensor_data, si_data_valid, rsp_*, busy. Asserting reset mid-transaction aborts it with no ack and no rsp; the datapath result is discarded.
- All outputs are registered or decoded from state registers. No combinational path from req or rsp_ready to any output.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, at a clock edge with req!=0: the arbiter grants the first set bit searching upward from the pointer, with wrap-around. req_data[grant] latches into the sample register. Next state is ISSUE. With req==0 the FSM stays in IDLE.
- ISSUE (exactly 1 cycle):
  - req_ack[grant]=1, si_data_valid=1, si_sensor_data=latched sample.
  - Wait count loads RESULT_LAT. Next state is WAIT.
- WAIT (RESULT_LAT cycles): si_data_valid=0; si_sensor_data holds the sample.
  - Count decrements each cycle.
  - On the edge ending the last WAIT cycle, capture si_processed_data into rsp_data and si_decision into rsp_decision. rsp_ch=grant. Next state is RESP.
- RESP: rsp_valid=1 with rsp_ch/rsp_data/rsp_decision stable until an edge with rsp_ready=1.
  - On that edge: pointer=(grant+1) mod N_CH, next state IDLE.
  - rsp_valid deasserts in the next cycle.
- Latency: req sampled at edge E0 gives ack and data_valid in cycle E0..E1. With rsp_ready=1, rsp_valid is high in cycle E(1+RESULT_LAT)..E(2+RESULT_LAT).
- Minimum transaction period: 3+RESULT_LAT cycles.
- Fairness: a continuously requesting channel waits at most N_CH-1 transactions.
- A req dropped before its ack is simply not granted; no error.
- A req held high after its ack is treated as a new request and re-arbitrated fairly in the next IDLE.
- New req arriving while busy: ignored until IDLE; no queueing.
- N_CH not a power of two: the pointer wraps from N_CH-1 to 0, never to an unused index.

Decomposition:
- Package sensor_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP), DATA_W default constant, grant-index helper function.
- Sub-module rr_arbiter (N_CH): inputs req, pointer; outputs one-hot grant, grant index, any_req. Purely combinational; the pointer register lives in sensor_scheduler.

Test Plan:
- Single channel: req=4'b0001, data0=16'h0020, rsp_ready=1 -> req_ack=4'b0001 for 1 cycle, si_data_valid 1 cycle with 16'h0020, rsp_valid 1 cycle later with rsp_ch=0 and rsp_data/rsp_decision equal to the datapath output.
- All request, held: req=4'b1111, data=16'h20/16'h80/16'h00/16'hFF -> acks in order ch0,1,2,3, then ch0 again. si_sensor_data sequence 20,80,00,FF. Each transaction 4 cycles (RESULT_LAT=1).
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and fields stable all 5 cycles, no new si_data_valid. On rsp_ready=1 the FSM returns to IDLE next cycle.
- Wrap and fairness: pointer at 3, req=4'b1001 -> ch3 granted, then ch0. With N_CH=3, pointer 2 -> next grant checks ch0 first.
- Reset mid-WAIT: rst_n low during WAIT (RESULT_LAT=3) -> all outputs 0 immediately (async). After release, req=4'b0010 is granted with pointer 0 behaviour and no stale rsp_valid.
- Latency sweep: RESULT_LAT=4 with a stub datapath whose result appears 4 cycles after data_valid -> captured rsp_data equals the stub's value, not the previous sample.
